// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: enables/flushes for IF/ID, ID/EX, EX/MEM, MEM/WB and the PC.
// Define HAZARD_PERF_CNT_EN to add stall_cycles / flush_events performance counters.
module pipe_hazard_ctrl #(
   parameter int MD_CYCLES = 32,
   parameter int CNT_W     = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_stall,
   input  logic        ex_md_start,
   input  logic        ex_branch_taken,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rd,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        ifid_flush,
   output logic        idex_en,
   output logic        idex_flush,
   output logic        exmem_en,
   output logic        exmem_flush,
   output logic        memwb_en,
`ifdef HAZARD_PERF_CNT_EN
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_events,
`endif
   output logic        md_busy,
   output logic        md_done
);

   typedef enum logic [0:0] {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

   // The start cycle and the done cycle are part of the freeze, hence the -2.
   localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 2);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load_use;
   logic             branch_evt;

   assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_rs1_used && (id_rs1 == ex_rd)) ||
                      (id_rs2_used && (id_rs2 == ex_rd)));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_en     = 1'b0;
      idex_flush  = 1'b0;
      exmem_en    = 1'b0;
      exmem_flush = 1'b0;
      memwb_en    = 1'b0;
      md_done     = 1'b0;
      branch_evt  = 1'b0;
      if (rst) begin
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
      end else if (mem_stall) begin
         // Everything holds, including an in-flight mul/div countdown.
      end else if (state_q == MD_WAIT && cnt_q != '0) begin
         exmem_en    = 1'b1;
         exmem_flush = 1'b1;
         memwb_en    = 1'b1;
         cnt_d       = cnt_q - CNT_W'(1);
      end else if (state_q == MD_WAIT) begin
         md_done  = 1'b1;
         pc_en    = 1'b1;
         ifid_en  = 1'b1;
         idex_en  = 1'b1;
         exmem_en = 1'b1;
         memwb_en = 1'b1;
         state_d  = RUN;
      end else if (ex_md_start) begin
         exmem_en    = 1'b1;
         exmem_flush = 1'b1;
         memwb_en    = 1'b1;
         state_d     = MD_WAIT;
         cnt_d       = MD_LOAD;
      end else if (ex_branch_taken) begin
         pc_en      = 1'b1;
         ifid_en    = 1'b1;
         ifid_flush = 1'b1;
         idex_en    = 1'b1;
         idex_flush = 1'b1;
         exmem_en   = 1'b1;
         memwb_en   = 1'b1;
         branch_evt = 1'b1;
      end else if (load_use) begin
         idex_en    = 1'b1;
         idex_flush = 1'b1;
         exmem_en   = 1'b1;
         memwb_en   = 1'b1;
      end else begin
         pc_en    = 1'b1;
         ifid_en  = 1'b1;
         idex_en  = 1'b1;
         exmem_en = 1'b1;
         memwb_en = 1'b1;
      end
   end

   assign md_busy = (state_q == MD_WAIT) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_events_q, flush_events_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_events_d = flush_events_q;
      if (!rst && !pc_en) stall_cycles_d = stall_cycles_q + 32'd1;
      if (branch_evt)     flush_events_d = flush_events_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= '0;
         flush_events_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_events_q <= flush_events_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_events = flush_events_q;
`else
   logic unused_branch_evt;
   assign unused_branch_evt = branch_evt;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB), all built from the DDF_en_rst primitive.
- Drives each register's enable and flush (flush is ORed into the register's rst) plus the PC enable.
- Resolves data-memory stalls, multi-cycle mul/div occupancy of EX, taken-branch squash and load-use bubbles, in a fixed priority order.

Parameters:
MD_CYCLES, 32, total EX occupancy in cycles of a mul/div op; legal range 2..64
CNT_W, 6, mul/div down-counter width; must satisfy 2**CNT_W >= MD_CYCLES

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset
mem_stall  in  1  data memory not ready this cycle
ex_md_start  in  1  instruction in EX is mul/div; held high while EX is frozen
ex_branch_taken  in  1  EX resolved a taken branch/jump
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  5  destination register of EX instruction
id_rs1  in  5  rs1 of ID instruction
id_rs2  in  5  rs2 of ID instruction
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
pc_en  out  1  PC register enable
ifid_en  out  1  IF/ID enable
ifid_flush  out  1  IF/ID flush (insert bubble)
idex_en  out  1  ID/EX enable
idex_flush  out  1  ID/EX flush
exmem_en  out  1  EX/MEM enable
exmem_flush  out  1  EX/MEM flush
memwb_en  out  1  MEM/WB enable
md_busy  out  1  FSM in MD_WAIT
md_done  out  1  single-cycle pulse on last mul/div cycle

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- State: FSM {RUN, MD_WAIT} and a CNT_W-bit down-counter cnt, both registered. All outputs are combinational from state, cnt and inputs.
- Reset: while rst=1, all *_en=0 and all *_flush=1, md_busy=0, md_done=0. The next edge loads state=RUN, cnt=0.
- A flush has priority over en in the downstream register. The flush outputs below are set only where stated; otherwise they are 0.
- Priority 1, mem_stall=1 (any state):
  - all *_en=0, all flushes 0, md_done=0.
  - state and cnt hold.
- Priority 2, state=MD_WAIT, cnt!=0:
  - pc_en=ifid_en=idex_en=0; exmem_en=1 with exmem_flush=1 (bubble into MEM); memwb_en=1.
  - cnt decrements each cycle.
- Priority 3, state=MD_WAIT, cnt==0:
  - md_done=1, all *_en=1.
  - next state=RUN; ex_branch_taken and load-use are ignored this cycle.
- Priority 4, state=RUN, ex_md_start=1:
  - same outputs as priority 2.
  - next state=MD_WAIT, cnt loads MD_CYCLES-2.
  - Total freeze of EX is therefore MD_CYCLES cycles, including the md_done cycle.
- Priority 5, RUN, ex_branch_taken=1:
  - all *_en=1, ifid_flush=1, idex_flush=1.
  - Overrides load-use, because the ID instruction is squashed anyway.
- Priority 6, RUN, load-use:
  - Condition: ex_mem_read=1 and ex_rd!=0, and either (id_rs1_used and id_rs1==ex_rd) or (id_rs2_used and id_rs2==ex_rd).
  - Outputs: pc_en=ifid_en=0, idex_en=1, idex_flush=1, exmem_en=memwb_en=1.
  - Exactly one bubble per hazard: the load leaves EX, so the condition clears next cycle.
- Priority 7, otherwise: all *_en=1.
- md_busy = (state==MD_WAIT).
- x0 never creates a hazard: ex_rd==0 suppresses load-use.
- mem_stall arriving mid-MD_WAIT freezes the countdown; the remaining count resumes when mem_stall drops.
- rst mid-MD_WAIT aborts the operation and returns to RUN; md_done is not pulsed.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds output ports stall_cycles[31:0] and flush_events[31:0]. Both reset to 0 and wrap modulo 2^32.
  - stall_cycles increments on every cycle with pc_en=0 and rst=0.
  - flush_events increments on every priority-5 cycle.
- When undefined, these ports and counters do not exist and the port list is exactly as above.

Test Plan:
- Reset: rst=1 for 2 cycles with ex_md_start=1 -> all *_en=0, all flushes=1, md_busy=0; after release with quiet inputs, all *_en=1.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_rs2_used=1 -> exactly one cycle with pc_en=0, ifid_en=0, idex_flush=1. Repeat with ex_rd=0 -> no stall.
- Mul/div, MD_CYCLES=4: ex_md_start=1 held -> pc_en=0 for 3 cycles with exmem_flush=1, md_done=1 on the 4th cycle, then RUN.
- mem_stall asserted for 2 cycles during MD_WAIT, MD_CYCLES=4 -> all *_en=0 and cnt frozen; md_done arrives 2 cycles later than in the previous scenario.
- ex_branch_taken=1 together with a load-use match -> ifid_flush=1, idex_flush=1, pc_en=1; no load-use stall.
- HAZARD_PERF_CNT_EN defined: 1 load-use hazard + 1 branch + MD_CYCLES=4 op -> stall_cycles=4, flush_events=1.
